// File: rtl/memif_cmd_issue_fifo.sv
// Per-thread memory command queue: a LUTRAM FIFO with a parity bit per entry that issues to the controller under credit flow control, at most one pop every two cycles.
// Optional MEMIF_PARITY_CHK_EN: checks parity at pop and drops corrupted entries, raising parity_err and leaving the credit untouched.
module memif_cmd_issue_fifo #(
    parameter int TIDW      = 6,
    parameter int IDXW      = 7,
    parameter int CREDITW   = 3,
    parameter int MAXCREDIT = 4
) (
    input  logic               gclk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [TIDW-1:0]    in_tid,
    input  logic [1:0]         in_cmd,
    input  logic [IDXW-1:0]    in_ret_index,
    input  logic [CREDITW-1:0] cmd_re,
    output logic               cmdfifo_empty,
    output logic               out_valid,
    output logic [TIDW-1:0]    out_tid,
    output logic [1:0]         out_cmd,
    output logic [IDXW-1:0]    out_ret_index,
    output logic               out_parity,
    output logic [CREDITW-1:0] ccnt,
    output logic               overflow_err,
    output logic               credit_err,
    output logic               parity_err
);
    localparam int DEPTH = 1 << TIDW;
    localparam int EW    = TIDW + 2 + IDXW + 1;
    localparam logic [TIDW:0]    FULL_CNT = {1'b1, {TIDW{1'b0}}};
    localparam logic [CREDITW:0] MAXC     = (CREDITW+1)'(MAXCREDIT);

    logic [EW-1:0]      r_mem [DEPTH];
    logic [TIDW-1:0]    r_head, r_tail;
    logic [TIDW:0]      r_count;
    logic               r_phase;
    logic [CREDITW-1:0] r_ccnt;
    logic               r_out_valid, r_out_parity;
    logic [TIDW-1:0]    r_out_tid;
    logic [1:0]         r_out_cmd;
    logic [IDXW-1:0]    r_out_idx;
    logic               r_overflow_err, r_credit_err;

    logic               w_full, w_empty, w_wr, w_pop, w_issue, w_par_ok, w_in_par;
    logic [EW-1:0]      w_head_ent;
    logic [CREDITW:0]   w_ccnt_sum;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_wr       = in_valid & ~w_full;
    assign w_in_par   = ^{in_tid, in_cmd, in_ret_index};
    assign w_head_ent = r_mem[r_head];
    // The count is registered, so a fresh entry cannot bypass into the same-cycle pop.
    assign w_pop      = ~r_phase & ~w_empty & (r_ccnt != '0);

`ifdef MEMIF_PARITY_CHK_EN
    logic r_parity_err;
    assign w_par_ok   = ~(^w_head_ent);
    assign parity_err = r_parity_err;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    // A dropped (corrupted) entry still advances head but neither issues nor spends a credit.
    assign w_issue    = w_pop & w_par_ok;
    assign w_ccnt_sum = {1'b0, r_ccnt} - {{CREDITW{1'b0}}, w_issue} + {1'b0, cmd_re};

    always_ff @(posedge gclk) begin
        if (w_wr && !rst) begin
            r_mem[r_tail] <= {in_tid, in_cmd, in_ret_index, w_in_par};
        end
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_phase        <= 1'b0;
            r_ccnt         <= MAXC[CREDITW-1:0];
            r_overflow_err <= 1'b0;
            r_credit_err   <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (w_wr) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (in_valid && w_full) begin
                r_overflow_err <= 1'b1;
            end
            if (w_ccnt_sum > MAXC) begin
                r_ccnt       <= MAXC[CREDITW-1:0];
                r_credit_err <= 1'b1;
            end else begin
                r_ccnt <= w_ccnt_sum[CREDITW-1:0];
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_tid    <= '0;
            r_out_cmd    <= '0;
            r_out_idx    <= '0;
            r_out_parity <= 1'b0;
        end else begin
            r_out_valid <= w_issue;
            if (w_issue) begin
                {r_out_tid, r_out_cmd, r_out_idx, r_out_parity} <= w_head_ent;
            end
        end
    end

`ifdef MEMIF_PARITY_CHK_EN
    always_ff @(posedge gclk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_pop & ~w_par_ok;
        end
    end
`endif

    assign cmdfifo_empty = w_empty;
    assign out_valid     = r_out_valid;
    assign out_tid       = r_out_tid;
    assign out_cmd       = r_out_cmd;
    assign out_ret_index = r_out_idx;
    assign out_parity    = r_out_parity;
    assign ccnt          = r_ccnt;
    assign overflow_err  = r_overflow_err;
    assign credit_err    = r_credit_err;
endmodule

// File: tb/tb_memif_cmd_issue_fifo.sv
// Bench for memif_cmd_issue_fifo: directed vector table, corner-case sequences and random traffic against a queue-based model.
module tb_memif_cmd_issue_fifo;
    logic       gclk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] in_tid = '0;
    logic [1:0] in_cmd = '0;
    logic [6:0] in_ret_index = '0;
    logic [2:0] cmd_re = '0;
    logic       cmdfifo_empty, out_valid, out_parity, overflow_err, credit_err, parity_err;
    logic [5:0] out_tid;
    logic [1:0] out_cmd;
    logic [6:0] out_ret_index;
    logic [2:0] ccnt;

    memif_cmd_issue_fifo dut (
        .gclk(gclk), .rst(rst), .in_valid(in_valid), .in_tid(in_tid), .in_cmd(in_cmd),
        .in_ret_index(in_ret_index), .cmd_re(cmd_re), .cmdfifo_empty(cmdfifo_empty),
        .out_valid(out_valid), .out_tid(out_tid), .out_cmd(out_cmd),
        .out_ret_index(out_ret_index), .out_parity(out_parity), .ccnt(ccnt),
        .overflow_err(overflow_err), .credit_err(credit_err), .parity_err(parity_err)
    );

    always #5 gclk = ~gclk;

    int n_chk = 0;
    int n_err = 0;
    int n_iss = 0;
    int got_tids[$];

    // Reference model: an ordered list of pending commands plus a credit integer.
    logic [16:0] m_q[$];   // {bad, tid, cmd, idx, parity}
    bit          m_phase;
    int          m_ccnt;
    bit          m_ovld, m_ov, m_cerr, m_perr;
    logic [15:0] m_out;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input logic [5:0] t, input logic [1:0] c,
                              input logic [6:0] x, input int re, input bit r);
        bit full, pop;
        int used, sum;
        logic [16:0] e;
        if (r) begin
            m_q.delete(); m_phase = 0; m_ccnt = 4; m_ovld = 0; m_out = '0;
            m_ov = 0; m_cerr = 0; m_perr = 0;
        end else begin
            full = (m_q.size() == 64);
            pop  = !m_phase && m_q.size() > 0 && m_ccnt > 0;
            m_ovld = 0; m_perr = 0; used = 0;
            if (pop) begin
                e = m_q.pop_front();
                if (e[16]) m_perr = 1;
                else begin m_ovld = 1; m_out = e[15:0]; used = 1; end
            end
            if (v) begin
                if (full) m_ov = 1;
                else m_q.push_back({1'b0, t, c, x, ^{t, c, x}});
            end
            sum = m_ccnt - used + re;
            if (sum > 4) begin sum = 4; m_cerr = 1; end
            m_ccnt = sum;
            m_phase = !m_phase;
        end
    endtask

    task automatic cyc(input bit v, input logic [5:0] t, input logic [1:0] c,
                       input logic [6:0] x, input logic [2:0] re, input bit r);
        in_valid = v; in_tid = t; in_cmd = c; in_ret_index = x; cmd_re = re; rst = r;
        @(posedge gclk);
        model_step(v, t, c, x, int'(re), r);
        #1;
        chk("out_valid", int'(out_valid), int'(m_ovld));
        chk("out_fields", int'({out_tid, out_cmd, out_ret_index, out_parity}), int'(m_out));
        chk("ccnt", int'(ccnt), m_ccnt);
        chk("empty", int'(cmdfifo_empty), int'(m_q.size() == 0));
        chk("overflow_err", int'(overflow_err), int'(m_ov));
        chk("credit_err", int'(credit_err), int'(m_cerr));
        chk("parity_err", int'(parity_err), int'(m_perr));
        if (out_valid) begin n_iss++; got_tids.push_back(int'(out_tid)); end
    endtask

    task automatic idle(input int n, input logic [2:0] re);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, re, 0);
    endtask

    typedef struct {
        bit v; logic [5:0] t; logic [1:0] c; logic [6:0] x; logic [2:0] re;
        bit e_ov; logic [5:0] e_t; logic [1:0] e_c; logic [6:0] e_x; bit e_p;
        int e_ccnt; bit e_empty; bit e_cerr;
    } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{0, 0, 0, 7'h00, 0,  0, 0, 0, 7'h00, 0,  4, 1, 0};
        vt[1] = '{1, 5, 2, 7'h11, 0,  0, 0, 0, 7'h00, 0,  4, 0, 0};
        vt[2] = '{0, 0, 0, 7'h00, 0,  1, 5, 2, 7'h11, 1,  3, 1, 0};
        vt[3] = '{0, 0, 0, 7'h00, 0,  0, 5, 2, 7'h11, 1,  3, 1, 0};
        vt[4] = '{0, 0, 0, 7'h00, 1,  0, 5, 2, 7'h11, 1,  4, 1, 0};
        vt[5] = '{1, 9, 1, 7'h22, 0,  0, 5, 2, 7'h11, 1,  4, 0, 0};
        vt[6] = '{0, 0, 0, 7'h00, 1,  1, 9, 1, 7'h22, 1,  4, 1, 0};
        vt[7] = '{0, 0, 0, 7'h00, 1,  0, 9, 1, 7'h22, 1,  4, 1, 1};

        #2;
        cyc(0, '0, '0, '0, '0, 1);
        chk("rst_ccnt", int'(ccnt), 4);
        chk("rst_empty", int'(cmdfifo_empty), 1);
        chk("rst_out_valid", int'(out_valid), 0);

        // First-issue latency and same-cycle pop/return credit handling
        for (int i = 0; i < 8; i++) begin
            cyc(vt[i].v, vt[i].t, vt[i].c, vt[i].x, vt[i].re, 0);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].e_ov));
            chk($sformatf("vec%0d_fields", i), int'({out_tid, out_cmd, out_ret_index, out_parity}),
                int'({vt[i].e_t, vt[i].e_c, vt[i].e_x, vt[i].e_p}));
            chk($sformatf("vec%0d_ccnt", i), int'(ccnt), vt[i].e_ccnt);
            chk($sformatf("vec%0d_empty", i), int'(cmdfifo_empty), int'(vt[i].e_empty));
            chk($sformatf("vec%0d_credit_err", i), int'(credit_err), int'(vt[i].e_cerr));
        end

        // Six back-to-back commands with four credits
        cyc(0, '0, '0, '0, '0, 1);
        n_iss = 0;
        for (int i = 0; i < 6; i++) cyc(1, 6'(i), 2'(i), 7'(i), 0, 0);
        idle(10, 0);
        chk("seq6_issued", n_iss, 4);
        chk("seq6_ccnt", int'(ccnt), 0);
        chk("seq6_empty", int'(cmdfifo_empty), 0);
        idle(1, 2);
        idle(8, 0);
        chk("seq6_total", n_iss, 6);
        chk("seq6_drained", int'(cmdfifo_empty), 1);

        // Fill to 64 with a wrapped head, overflow, then drain in order
        cyc(0, '0, '0, '0, '0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 6'd63, 2'd3, 7'd0, 0, 0);
        idle(10, 0);
        chk("fill_ccnt0", int'(ccnt), 0);
        got_tids.delete();
        for (int i = 0; i < 64; i++) cyc(1, 6'(i), 2'(i), 7'(i), 0, 0);
        chk("fill_no_ovf", int'(overflow_err), 0);
        cyc(1, 6'd42, 2'd1, 7'd42, 0, 0);
        chk("ovf_set", int'(overflow_err), 1);
        for (int k = 0; k < 400 && got_tids.size() < 64; k++)
            cyc(0, '0, '0, '0, (m_ccnt < 4) ? 3'd1 : 3'd0, 0);
        idle(6, 0);
        chk("drain_count", got_tids.size(), 64);
        for (int i = 0; i < 64 && i < got_tids.size(); i++)
            chk($sformatf("drain_order%0d", i), got_tids[i], i);
        chk("drain_empty", int'(cmdfifo_empty), 1);

        // Reset with three queued entries and one credit left
        cyc(0, '0, '0, '0, '0, 1);
        cyc(1, 6'd10, 2'd1, 7'd1, 3'd4, 0);
        for (int i = 1; i < 6; i++) cyc(1, 6'(10 + i), 2'd1, 7'(i), 0, 0);
        idle(1, 0);
        chk("pre_rst_ccnt", int'(ccnt), 1);
        chk("pre_rst_cerr", int'(credit_err), 1);
        cyc(0, '0, '0, '0, '0, 1);
        chk("mid_rst_empty", int'(cmdfifo_empty), 1);
        chk("mid_rst_ccnt", int'(ccnt), 4);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_cerr", int'(credit_err), 0);

`ifdef MEMIF_PARITY_CHK_EN
        n_iss = 0;
        cyc(1, 6'd1, 2'd1, 7'd3, 0, 0);
        dut.r_mem[0][1] = ~dut.r_mem[0][1];
        m_q[0][16] = 1'b1;
        cyc(1, 6'd2, 2'd2, 7'd4, 0, 0);
        cyc(0, '0, '0, '0, '0, 0);
        chk("par_err_pulse", int'(parity_err), 1);
        chk("par_no_credit", int'(ccnt), 4);
        idle(4, 0);
        chk("par_next_issued", n_iss, 1);
        cyc(0, '0, '0, '0, '0, 1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] re;
            re = '0;
            if (m_ccnt < 4 && $urandom_range(0, 1) == 1) re = 3'd1;
            if ($urandom_range(0, 49) == 0) re = 3'($urandom_range(0, 4));
            cyc($urandom_range(0, 99) < 60, 6'($urandom), 2'($urandom), 7'($urandom), re,
                $urandom_range(0, 399) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/memif_cmd_issue_fifo.md
# memif_cmd_issue_fifo

Per-thread memory command queue between the IU memory-op stage and the memory controller. Accepts one I- or D-side command per cycle, tagged with thread ID and return index, and stores it in a LUTRAM FIFO with a parity bit. Issues commands to the memory controller under credit-based flow control, popping at most once every two cycles. Credits are returned by the controller through its `cmd_re` count.

## Interface
- One clock; reset is synchronous and active-high. Clock is `gclk`, reset is `rst`.
- Parameters:
- `TIDW`, 6: thread ID width; FIFO depth is 2^TIDW.
- `IDXW`, 7: return-index width (I/D union width).
- `CREDITW`, 3: credit counter width.
- `MAXCREDIT`, 4: credits held after reset; must be ≤ 2^CREDITW−1.
- Ports:
- `gclk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: enqueue strobe.
- `in_tid` in TIDW: thread ID.
- `in_cmd` in 2: I/D memory op.
- `in_ret_index` in IDXW: write-back block index.
- `cmd_re` in CREDITW: credits returned this cycle (0..MAXCREDIT).
- `cmdfifo_empty` out 1: FIFO empty.
- `out_valid` out 1: registered command valid, one-cycle pulse.
- `out_tid`, `out_cmd`, `out_ret_index`, `out_parity` out TIDW/2/IDXW/1: registered command fields.
- `ccnt` out CREDITW: current credit count.
- `overflow_err` out 1: sticky error; set by an enqueue while full.
- `credit_err` out 1: sticky error; set by a return that would exceed MAXCREDIT.
- `parity_err` out 1: one-cycle pulse; only with the macro, see Configuration.

## Operation
- Storage: LUTRAM of 2^TIDW entries, each {tid, cmd, ret_index, parity}.
  - `parity` = ^{in_tid, in_cmd, in_ret_index}, computed at enqueue.
  - Head and tail pointers are TIDW bits with natural wrap. A separate count (TIDW+1 bits) distinguishes full from empty.
- Enqueue: when `in_valid` and not full, write at tail and increment tail.
  - `in_valid` while full drops the command and sets `overflow_err`.
- Phase bit: reset to 0, toggles every cycle.
- Pop condition (`fifo_re`): phase==0, FIFO not empty, and ccnt≠0.
  - A pop increments head.
  - The output register loads the head entry, and `out_valid`=1 on the next cycle.
- Credits:
  - ccnt_next = ccnt − pop + cmd_re. Pop and return in the same cycle are both applied.
  - If the sum exceeds MAXCREDIT, clamp ccnt to MAXCREDIT and set `credit_err`.
- Simultaneous enqueue and pop:
  - Both apply; the count is unchanged.
  - When empty, there is no bypass: the new entry is popped no earlier than the next eligible phase.
- `cmdfifo_empty` is combinational from the count.

## Timing
- Reset values:
  - Head, tail, count = 0; phase = 0; ccnt = MAXCREDIT.
  - `out_valid` = 0. Output fields = 0.
  - `cmdfifo_empty` = 1; `overflow_err` = `credit_err` = `parity_err` = 0.
  - LUTRAM contents are not cleared.
- Enqueue at cycle t: entry is visible at t+1 (`cmdfifo_empty`=0).
- Pop at t: `out_valid` is high at t+1 only. Output fields hold their value until the next load.
- Minimum enqueue-to-`out_valid` latency is 2 cycles (phase 0 at t+1); otherwise 3 cycles.
- Maximum issue rate is one command per 2 cycles.
- The `cmd_re` return at cycle t is usable by a pop at t+1.
- Reset asserted mid-operation: all state returns to its reset value at the next edge. In-flight commands are discarded and credits are restored.

## Configuration
- Macro `MEMIF_PARITY_CHK_EN`.
- Defined:
  - At pop, the stored parity is recomputed against the stored fields.
  - On mismatch: `out_valid` stays 0, `parity_err` pulses at t+1, the entry is still consumed (head advances), and no credit is consumed.
- Undefined:
  - No check is performed; the stored parity passes through to `out_parity`.
  - `parity_err` is tied to 0, and pop always consumes a credit.

## Test plan
- Reset, then enqueue tid=5, cmd=2, idx=0x11 at cycle 1 → `out_valid` at cycle 3 with {5,2,0x11}, correct parity, ccnt 4→3.
- Enqueue 6 commands back to back with no credit returns → exactly 4 issued on alternate cycles, ccnt=0, 2 remain, `cmdfifo_empty`=0. Then drive `cmd_re`=2 → the remaining 2 issue.
- Fill 64 entries, enqueue a 65th → `overflow_err`=1, count stays 64. Drain all with credits → wrap-around order preserved, tids 0..63.
- Pop and `cmd_re`=1 in the same cycle at ccnt=4 → ccnt remains 4, no `credit_err`. With ccnt=4 and `cmd_re`=1, no pop → ccnt=4, `credit_err`=1.
- Assert `rst` while 3 entries are queued and ccnt=1 → next cycle: empty=1, ccnt=4, `out_valid`=0, error flags cleared.
- With `MEMIF_PARITY_CHK_EN`, force-corrupt one stored bit → `parity_err` pulse, no `out_valid`, ccnt unchanged, following entry issues normally.
